// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: captures the FIR's registered output one cycle after each
// output_ready pulse into a circular FIFO, and presents the head sample over a
// valid/ack handshake. Also reports occupancy and a sticky overflow flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no capture pending this cycle
//   S_CAPTURE| fir_out holds a fresh sample; write it at the end of cycle
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic signed [WIDTH-1:0]  fir_out,
    input  logic                     fir_output_ready,
    output logic signed [WIDTH-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic signed [WIDTH-1:0] mem [DEPTH];

    logic wr_en;
    logic pop;
    logic full;
    logic do_write;
    logic drop;

    // Handshake decode, next-state and pointer/occupancy arithmetic.
    always_comb begin
        wr_en      = (state_q == S_CAPTURE);
        pop        = out_valid & out_ack;
        full       = (count_q == CW'(DEPTH));
        // When full, a simultaneous pop frees the slot the write lands in.
        do_write   = wr_en & (~full | pop);
        drop       = wr_en & full & ~pop;

        state_d    = fir_output_ready ? S_CAPTURE : S_IDLE;
        wr_ptr_d   = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d    = count_q;
        if (do_write && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_write && pop) begin
            count_d = count_q - CW'(1);
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Control state: capture FSM, pointers, occupancy and sticky overflow.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Sample storage; contents are deliberately left unreset.
    always_ff @(posedge ck) begin
        if (do_write) begin
            mem[wr_ptr_q] <= fir_out;
        end
    end

    // Outputs derive from registers only; data is zeroed while empty.
    always_comb begin
        out_valid = (count_q != '0);
        out_data  = out_valid ? mem[rd_ptr_q] : '0;
        count     = count_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: a vector table for basic capture/pop
// timing, then hand-written sequences for wrap, overflow, full write+pop,
// clear race and asynchronous reset.
module tb_fir_sample_fifo;

    logic               ck;
    logic               rst;
    logic signed [15:0] fir_out;
    logic               fir_output_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ack;
    logic [3:0]         count;
    logic               overflow;
    logic               clear_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    fir_sample_fifo #(.WIDTH(16), .DEPTH(8)) dut (
        .ck               (ck),
        .rst              (rst),
        .fir_out          (fir_out),
        .fir_output_ready (fir_output_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ack          (out_ack),
        .count            (count),
        .overflow         (overflow),
        .clear_overflow   (clear_overflow)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic [15:0] din;
        logic        ack;
        logic        clr;
        logic        e_valid;
        logic [15:0] e_data;
        logic [3:0]  e_count;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic set_in(input logic r, input logic [15:0] d, input logic a, input logic c);
        fir_output_ready = r;
        fir_out          = d;
        out_ack          = a;
        clear_overflow   = c;
    endtask

    initial begin
        int popped;

        //          rdy din      ack clr  valid data     cnt ovf
        vecs[0]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234, 4'd1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[4]  = '{1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b1, 16'h0AAA, 4'd1, 1'b0};
        vecs[5]  = '{1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 16'h0AAA, 4'd2, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFE, 4'd1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[9]  = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};
        vecs[10] = '{1'b0, 16'h0111, 1'b0, 1'b0, 1'b1, 16'h0111, 4'd1, 1'b0};
        vecs[11] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0111, 4'd1, 1'b0};
        vecs[12] = '{1'b0, 16'h0222, 1'b1, 1'b0, 1'b1, 16'h0222, 4'd1, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b0};

        rst = 1'b0;
        set_in(1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        check("reset_count", 16'(count), 16'd0);
        check("reset_valid", 16'(out_valid), 16'd0);
        check("reset_data", out_data, 16'h0000);
        check("reset_ovf", 16'(overflow), 16'd0);
        step();
        rst = 1'b1;

        // Vector table: single sample, back-to-back pulses, empty ack, write+pop.
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].rdy, vecs[i].din, vecs[i].ack, vecs[i].clr);
            step();
            check($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].e_valid));
            check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
            check($sformatf("vec%0d_count", i), 16'(count), 16'(vecs[i].e_count));
            check($sformatf("vec%0d_ovf", i), 16'(overflow), 16'(vecs[i].e_ovf));
        end

        // Ordering across pointer wrap: -5..6, popping from cycle 5 on.
        popped = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            set_in(cyc < 12, (cyc >= 1 && cyc <= 12) ? 16'(cyc - 6) : 16'h0, cyc >= 5, 1'b0);
            if (out_valid && out_ack) begin
                check($sformatf("wrap_pop%0d", popped), out_data, 16'(popped - 5));
                popped++;
            end
            step();
        end
        check("wrap_popped", 16'(popped), 16'd12);
        check("wrap_ovf", 16'(overflow), 16'd0);
        check("wrap_count", 16'(count), 16'd0);

        // Full and overflow: 1..9 with no ack, 9 dropped.
        for (int cyc = 0; cyc < 10; cyc++) begin
            set_in(cyc < 9, (cyc >= 1) ? 16'(cyc) : 16'h0, 1'b0, 1'b0);
            step();
        end
        check("full_count", 16'(count), 16'd8);
        check("full_ovf", 16'(overflow), 16'd1);
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b0, 16'h0, 1'b1, 1'b0);
            check($sformatf("drain%0d", k), out_data, 16'(k));
            step();
        end
        set_in(1'b0, 16'h0, 1'b0, 1'b0);
        check("drain_valid", 16'(out_valid), 16'd0);
        check("drain_ovf_sticky", 16'(overflow), 16'd1);
        set_in(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        check("clr_ovf", 16'(overflow), 16'd0);

        // Write and pop while full: fill 10..17, then capture 99 with ack.
        for (int cyc = 0; cyc < 9; cyc++) begin
            set_in(cyc < 8, (cyc >= 1) ? 16'(cyc + 9) : 16'h0, 1'b0, 1'b0);
            step();
        end
        check("fill2_count", 16'(count), 16'd8);
        set_in(1'b1, 16'h0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 16'd99, 1'b1, 1'b0);
        check("wp_head_before", out_data, 16'd10);
        step();
        set_in(1'b0, 16'h0, 1'b0, 1'b0);
        check("wp_count", 16'(count), 16'd8);
        check("wp_ovf", 16'(overflow), 16'd0);
        check("wp_head_after", out_data, 16'd11);

        // Clear race: drop and clear in the same cycle, then clear alone.
        set_in(1'b1, 16'h0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 16'h5555, 1'b0, 1'b1);
        step();
        check("race_ovf", 16'(overflow), 16'd1);
        check("race_count", 16'(count), 16'd8);
        check("race_head", out_data, 16'd11);
        set_in(1'b0, 16'h0, 1'b0, 1'b1);
        step();
        check("race_clr", 16'(overflow), 16'd0);

        // Async reset with count=5 and a capture pending.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 16'h0, 1'b1, 1'b0);
            step();
        end
        check("pre_rst_count", 16'(count), 16'd5);
        check("pre_rst_head", out_data, 16'd14);
        set_in(1'b1, 16'h0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 16'h7777, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 16'(count), 16'd0);
        check("arst_valid", 16'(out_valid), 16'd0);
        check("arst_data", out_data, 16'h0000);
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
        end
        check("post_rst_count", 16'(count), 16'd0);
        check("post_rst_valid", 16'(out_valid), 16'd0);
        check("post_rst_data", out_data, 16'h0000);
        check("post_rst_ovf", 16'(overflow), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
